// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink peripheral: register offsets, reset constants,
// LED vector type and the Wishbone byte-enable mask helper.
package led_blink_pkg;

   localparam logic [1:0] REG_LED_VAL    = 2'd0;
   localparam logic [1:0] REG_BLINK_MASK = 2'd1;
   localparam logic [1:0] REG_PERIOD     = 2'd2;
   localparam logic [1:0] REG_CTRL       = 2'd3;

   localparam logic [7:0] DUTY_RESET = 8'hFF;

   typedef logic [7:0] led_t;

   function automatic logic [31:0] sel_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running half-blink prescaler: counts 0..period-1 and toggles phase on wrap.
// A clear restarts the count but never suppresses a coincident phase toggle.
module blink_prescaler
   import led_blink_pkg::*;
#(
   parameter int PRESC_WIDTH = 24
) (
   input  logic                   clk_sys,
   input  logic                   rst,
   input  logic [PRESC_WIDTH-1:0] period,
   input  logic                   clear,
   output logic [PRESC_WIDTH-1:0] cnt,
   output logic                   phase
);

   logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
   logic                   phase_q, phase_d;
   logic                   wrap;

   always_comb begin
      wrap    = (cnt_q == period - PRESC_WIDTH'(1));
      cnt_d   = cnt_q + PRESC_WIDTH'(1);
      phase_d = phase_q;
      if (wrap) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
      if (clear) cnt_d = '0;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign cnt   = cnt_q;
   assign phase = phase_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Wishbone LED peripheral: static pattern, per-LED blink mask, programmable blink period.
// Optional global PWM dimming is built when LED_PWM_EN is defined.
module led_blink_ctrl
   import led_blink_pkg::*;
#(
   parameter int                     PRESC_WIDTH  = 24,
   parameter logic [PRESC_WIDTH-1:0] RESET_PERIOD = PRESC_WIDTH'(5_000_000)
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic [7:0]  led
);

   led_t                   led_val_q, led_val_d;
   led_t                   mask_q, mask_d;
   led_t                   led_q, led_d;
   logic [PRESC_WIDTH-1:0] period_q, period_d;
   logic                   ack_q, ack_d;
   logic [31:0]            dat_q, dat_d;

   logic                   req, wr;
   logic                   period_wr_en;
   logic [31:0]            wmask, pmerge, rdata;
   logic [PRESC_WIDTH-1:0] period_wr;
   logic [PRESC_WIDTH-1:0] presc_cnt;
   logic                   phase;
   logic                   pwm_on;
   logic [7:0]             duty_rd;

   // ack_q in the request term spaces back-to-back accesses two cycles apart
   assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr    = req & wb_we_i;
   assign wmask = sel_mask(wb_sel_i);

   always_comb begin
      pmerge    = (32'(period_q) & ~wmask) | (wb_dat_i & wmask);
      period_wr = pmerge[PRESC_WIDTH-1:0];
   end

`ifdef LED_PWM_EN
   logic [7:0] duty_q, duty_d;
   logic [7:0] pwm_cnt_q, pwm_cnt_d;

   always_comb begin
      duty_d    = duty_q;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
      if (wr && wb_adr_i[3:2] == REG_CTRL && wb_sel_i[1]) duty_d = wb_dat_i[15:8];
      pwm_on  = (pwm_cnt_q < duty_q) | (duty_q == 8'hFF);
      duty_rd = duty_q;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         duty_q    <= DUTY_RESET;
         pwm_cnt_q <= '0;
      end else begin
         duty_q    <= duty_d;
         pwm_cnt_q <= pwm_cnt_d;
      end
   end
`else
   assign pwm_on  = 1'b1;
   assign duty_rd = 8'h00;
`endif

   always_comb begin
      rdata = '0;
      case (wb_adr_i[3:2])
         REG_LED_VAL:    rdata = {24'b0, led_val_q};
         REG_BLINK_MASK: rdata = {24'b0, mask_q};
         REG_PERIOD:     rdata = 32'(period_q);
         default:        rdata = {16'b0, duty_rd, 7'b0, phase};
      endcase
   end

   always_comb begin
      led_val_d    = led_val_q;
      mask_d       = mask_q;
      period_d     = period_q;
      period_wr_en = 1'b0;
      ack_d        = req;
      dat_d        = '0;
      if (wr) begin
         case (wb_adr_i[3:2])
            REG_LED_VAL:    if (wb_sel_i[0]) led_val_d = wb_dat_i[7:0];
            REG_BLINK_MASK: if (wb_sel_i[0]) mask_d = wb_dat_i[7:0];
            REG_PERIOD: begin
               period_wr_en = 1'b1;
               period_d     = (period_wr == '0) ? PRESC_WIDTH'(1) : period_wr;
            end
            default: ;
         endcase
      end
      if (req && !wb_we_i) dat_d = rdata;
      led_d = led_val_q & (~mask_q | {8{phase}}) & {8{pwm_on}};
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         led_val_q <= '0;
         mask_q    <= '0;
         period_q  <= RESET_PERIOD;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         led_q     <= '0;
      end else begin
         led_val_q <= led_val_d;
         mask_q    <= mask_d;
         period_q  <= period_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         led_q     <= led_d;
      end
   end

   blink_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
      .clk_sys (clk_sys),
      .rst     (rst),
      .period  (period_q),
      .clear   (period_wr_en),
      .cnt     (presc_cnt),
      .phase   (phase)
   );

   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[1:0], pmerge, presc_cnt};

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign led      = led_q;

endmodule

// File: doc/led_blink_ctrl.md
# led_blink_ctrl

Wishbone-slave LED peripheral in the lt16soc that drives the 8-bit `led` output of `lt16soc_top`; it sits directly upstream of the board LEDs and downstream of the CPU data bus. Software writes a static LED pattern, a per-LED blink mask and a blink period. A free-running prescaler then toggles the masked LEDs autonomously. An optional PWM stage dims all LEDs globally.

## Interface
- `PRESC_WIDTH`, 24: width of the blink prescaler and PERIOD register.
- `RESET_PERIOD`, 24'd5_000_000: PERIOD value after reset, in clk_sys cycles per half-blink.
- `clk_sys` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wb_cyc_i` input 1: bus cycle valid.
- `wb_stb_i` input 1: strobe.
- `wb_we_i` input 1: 1 = write.
- `wb_adr_i` input 4: byte address; bits [3:2] select the register, bits [1:0] are ignored.
- `wb_sel_i` input 4: byte enables for writes.
- `wb_dat_i` input 32: write data.
- `wb_dat_o` output 32: read data, registered.
- `wb_ack_o` output 1: single-cycle acknowledge.
- `led` output 8: LED drive, registered.

## Operation
- Register map:
  - 0x0 LED_VAL [7:0] RW.
  - 0x4 BLINK_MASK [7:0] RW.
  - 0x8 PERIOD [PRESC_WIDTH-1:0] RW.
  - 0xC CTRL: bit0 PHASE RO; [15:8] DUTY RW only under LED_PWM_EN.
  - Unimplemented bits read 0, and writes to them are ignored.
- Writes honour `wb_sel_i` per byte; a byte with sel=0 keeps its value.
- Prescaler `cnt` counts 0..PERIOD-1. On the cycle where `cnt`==PERIOD-1, `cnt` returns to 0 and PHASE toggles.
- A PERIOD write of 0 is stored as 1. With PERIOD=1, PHASE toggles every cycle.
- A write to PERIOD (any byte) clears `cnt` to 0 on the same edge. PHASE is unchanged.
- If a PERIOD write and a wrap occur in the same cycle, the write wins: `cnt`=0 and PHASE still toggles.
- Next-state LED: `led_n[i] = LED_VAL[i] & (~BLINK_MASK[i] | PHASE) & pwm_on`; `led` <= `led_n` every cycle.
- Writes to bit0 of CTRL are ignored.
- Reset values:
  - LED_VAL=0, BLINK_MASK=0, PERIOD=RESET_PERIOD, `cnt`=0, PHASE=0.
  - DUTY=8'hFF.
  - `led`=0, `wb_ack_o`=0, `wb_dat_o`=0.
- A reset asserted mid-transaction aborts it: no ack is issued and all registers return to their reset values on that edge.

## Timing
- Access handshake:
  - A request is `wb_cyc_i & wb_stb_i & ~wb_ack_o`.
  - `wb_ack_o` rises on the edge after the request and stays high exactly 1 cycle.
  - If stb remains high, the next ack follows 2 cycles later, so at most 1 access per 2 cycles.
- Writes: the register updates on the same edge that raises `wb_ack_o`.
- Reads: `wb_dat_o` is valid while `wb_ack_o`=1; otherwise it holds 0.
- Latency from a register write to `led`:
  - The written value is in the register 1 cycle after the request.
  - `led` reflects it 2 cycles after the request.
- Latency from a PHASE toggle to `led`: 1 cycle.
- `cnt` and PHASE run regardless of bus activity.

## Configuration
- Macro: `LED_PWM_EN`.
- Defined:
  - An 8-bit free-running `pwm_cnt` (reset 0) increments every cycle and wraps 255→0.
  - `pwm_on = (pwm_cnt < DUTY) | (DUTY == 8'hFF)`.
  - DUTY=0 keeps all LEDs off.
  - CTRL[15:8] is RW.
- Not defined:
  - `pwm_on` = 1 constantly and no `pwm_cnt` exists.
  - CTRL[15:8] reads 0 and writes to it are ignored.

## Structure
- Shared package `led_blink_pkg`:
  - Register offset constants REG_LED_VAL=2'd0, REG_BLINK_MASK=2'd1, REG_PERIOD=2'd2, REG_CTRL=2'd3.
  - DUTY reset constant.
  - Typedef `led_t` (logic [7:0]).
- Sub-module `blink_prescaler`:
  - Inputs: clk_sys, rst, period, clear.
  - Outputs: cnt, phase.
- Bus decode and LED output register stay in the top module.

## Test plan
- Reset check: hold `rst`=1 for 2 cycles, then release and read 0x8 → `wb_dat_o`=5_000_000 with ack 1 cycle after the request; `led`=8'h00.
- Static pattern with blink: write LED_VAL=8'hA5 with sel=4'b0001, then read 0x0 → 8'hA5; `led`=8'hA5 2 cycles after the write request. Then write BLINK_MASK=8'h0F and PERIOD=4 → `led` alternates 8'hA0/8'hA5 every 4 cycles, starting 8'hA0 because PHASE=0.
- PERIOD edge case: write PERIOD=0, then read back 1 → PHASE toggles every cycle.
- Period write at wrap: issue a PERIOD write so the register update coincides with `cnt`==PERIOD-1 → PHASE toggles and `cnt`=0.
- Byte enables: write 0xFFFF_FF00 to 0x0 with sel=4'b1110 → LED_VAL unchanged at 8'hA5. Write to 0xC bit0 → PHASE unaffected.
- PWM, with LED_PWM_EN defined: DUTY=8'h40, LED_VAL=8'hFF, BLINK_MASK=0 → `led`=8'hFF for exactly 64 of every 256 cycles. DUTY=0 → `led` stays 0. Without the macro, a read of 0xC returns [15:8]=0.
- Mid-transaction reset: assert `rst` while stb is high → no ack, all registers return to their reset values, and `led`=0 on the next cycle.
